ahb_lite_sram_slave: RTL and testbench
======================================

Name: ahb_lite_sram_slave

Overview:
AHB-Lite slave (responder) with on-chip word-organised scratch memory. It completes transfers issued by the bus masters through the AHB-Lite master mux, and sits behind the address decoder on the shared bus. It supports byte, halfword and word accesses, a configurable number of wait states, and the two-cycle ERROR response for illegal transfers.

Parameters:
DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KB)
BASE_ADDR, 32'h2000_0000, byte address of word 0; must be aligned to 4*2^DEPTH_LOG2
WAIT_STATES, 0, HREADYOUT-low cycles inserted per valid transfer data phase (0..7)

Ports:
clk  in  1  bus clock
n_Rst  in  1  reset, asynchronous, active-low
HSEL  in  1  slave select from decoder
HADDR  in  32  address-phase byte address
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE  in  1  1 = write
HSIZE  in  3  000 byte, 001 halfword, 010 word; others illegal
HBURST  in  3  accepted, ignored (each beat is decoded independently)
HPROT  in  4  accepted, ignored
HWDATA  in  32  write data, data phase
HREADY  in  1  bus-wide ready (HREADY driven back by the mux/bus)
HREADYOUT  out  1  this slave's ready
HRESP  out  2  00 OKAY, 01 ERROR
HRDATA  out  32  read data

Behaviour:
- Reset (async, n_Rst=0): state IDLE, HREADYOUT=1, HRESP=00, HRDATA=0, data-phase registers cleared. Memory contents are not reset. Reset mid-transfer abandons the transfer; no memory write occurs.
- Address-phase accept condition: HSEL & HREADY & HTRANS[1] on a rising clk edge.
  - At accept, latch addr, size, write into data-phase registers.
  - IDLE/BUSY, HSEL=0, or HREADY=0 causes no accept. If no data phase is pending, the slave stays in or returns to IDLE (zero-wait OKAY).
- Illegal transfer (checked at accept):
  - HSIZE>010.
  - Misaligned: halfword with HADDR[0]=1, or word with HADDR[1:0]!=00.
  - HADDR outside [BASE_ADDR, BASE_ADDR+4*2^DEPTH_LOG2-1].
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=00. On legal accept: go to WAIT if WAIT_STATES>0, else stay IDLE with a data phase pending. On illegal accept: go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=00. A counter loads WAIT_STATES-1 at accept and decrements each cycle. At 0, the next cycle is the completing cycle: HREADYOUT=1, OKAY.
  - ERR1: HREADYOUT=0, HRESP=01, exactly one cycle, then ERR2.
  - ERR2: HREADYOUT=1, HRESP=01. A new address phase may be accepted in this cycle; the next state is decided by it.
- Completing cycle: the data-phase cycle with HREADYOUT=1. A new accept may occur in the same cycle (pipelined). Back-to-back zero-wait transfers therefore sustain 1 transfer/cycle.
- Write: HWDATA is sampled on the completing cycle's clock edge. Lanes are little-endian.
  - byte: lane = addr[1:0].
  - halfword: lanes {addr[1],0} and {addr[1],1}.
  - word: all lanes.
  - Unselected lanes are unchanged. No write on ERROR.
- Read: HRDATA = full memory word at the latched word index, valid in the completing cycle. HRDATA=0 in all other cycles and on ERROR. All 4 lanes are driven; the master selects lanes.
- Write followed immediately by read of the same word: the read returns the newly written data. The write commits at the edge that starts the read data phase, and the read is combinational from the array.
- Word index = (addr - BASE_ADDR)[DEPTH_LOG2+1:2].
- HREADY=0 from another slave while this slave is idle: address ignored, no state change.

Test Plan:
- WAIT_STATES=0:
  - Write word 32'hDEADBEEF @BASE_ADDR → HREADYOUT stays 1, HRESP=00.
  - Following read @BASE_ADDR → HRDATA=32'hDEADBEEF in the next cycle.
- Byte writes: after writing 32'h0, write byte 8'hA5 @BASE_ADDR+3 with HWDATA=32'hA5xxxxxx, then read the word → 32'hA500_0000. Repeat with halfword 16'h1234 @BASE_ADDR+2 → 32'h1234_0000.
- WAIT_STATES=2, NONSEQ read:
  - HREADYOUT low exactly 2 cycles after accept, high on the 3rd with correct HRDATA.
  - Next NONSEQ presented during the waits is not accepted until HREADY=1.
- Word write @BASE_ADDR+2 (misaligned) → HREADYOUT=0/HRESP=01 for one cycle, then HREADYOUT=1/HRESP=01; memory unchanged on read-back. Same check for HSIZE=011 and for HADDR=BASE_ADDR+4*2^DEPTH_LOG2.
- Pipelined sequence write A, read A, write B, read B (zero wait) → 4 completions in 4 cycles, read data correct, HTRANS IDLE interleaved gives OKAY.
- Reset mid-transfer: WAIT_STATES=3, assert n_Rst during the 2nd wait cycle of a write → outputs immediately HREADYOUT=1, HRESP=00, HRDATA=0; the target word keeps its old value.

Source files
------------

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite responder backed by a word-organised scratch RAM with byte lanes,
// configurable wait states and the two-cycle ERROR response.
module ahb_lite_sram_slave #(
    parameter int          DEPTH_LOG2  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        n_Rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int          AW        = DEPTH_LOG2;
    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t         state_q;
    logic           pend_q;
    logic           write_q;
    logic [AW-1:0]  idx_q;
    logic [3:0]     be_q;
    logic [2:0]     cnt_q;

    logic [31:0]    mem [0:DEPTH-1];

    logic           accept;
    logic           illegal;
    logic           complete;
    logic [AW-1:0]  idx_d;
    logic [3:0]     be_d;
    logic           unused_ok;

    // An address phase is taken when the bus is ready and the master issues
    // NONSEQ/SEQ to us; the data phase completes on the cycle HREADYOUT is high.
    assign accept = HSEL & HREADY & HTRANS[1];

    assign illegal = (HSIZE > 3'b010)
                   | ((HSIZE == 3'b001) & HADDR[0])
                   | ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00))
                   | (HADDR[31:AW+2] != BASE_ADDR[31:AW+2]);

    assign idx_d = HADDR[AW+1:2];

    always_comb begin
        be_d = 4'b1111;
        case (HSIZE)
            3'b000:  be_d = 4'b0001 << HADDR[1:0];
            3'b001:  be_d = HADDR[1] ? 4'b1100 : 4'b0011;
            default: ;
        endcase
    end

    assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

    always_ff @(posedge clk or negedge n_Rst) begin
        if (!n_Rst) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            write_q <= 1'b0;
            idx_q   <= '0;
            be_q    <= 4'b0000;
            cnt_q   <= 3'd0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == 3'd0) state_q <= ST_IDLE;
                    else               cnt_q   <= cnt_q - 3'd1;
                end
                ST_ERR1: state_q <= ST_ERR2;
                default: begin
                    // IDLE (possibly completing a data phase) and ERR2 both
                    // take the next address phase.
                    state_q <= ST_IDLE;
                    pend_q  <= 1'b0;
                    if (accept) begin
                        write_q <= HWRITE;
                        idx_q   <= idx_d;
                        be_q    <= be_d;
                        if (illegal) begin
                            state_q <= ST_ERR1;
                        end else begin
                            pend_q <= 1'b1;
                            if (WAIT_STATES > 0) begin
                                state_q <= ST_WAIT;
                                cnt_q   <= WAIT_LOAD;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign complete = pend_q & (state_q == ST_IDLE);

    always_ff @(posedge clk) begin
        if (complete && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    assign HREADYOUT = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
    assign HRDATA    = (complete && !write_q) ? mem[idx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave: three instances (0, 2 and 3 wait
// states) on a shared bus, read data checked through an expected queue.
module tb_ahb_lite_sram_slave;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [2:0]  hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready_ovr;

    logic        hro0, hro1, hro2;
    logic [1:0]  hresp0, hresp1, hresp2;
    logic [31:0] hrdata0, hrdata1, hrdata2;
    logic        hready0, hready1, hready2;

    logic [1:0]  inst;
    logic        cur_hro;
    logic [1:0]  cur_hresp;
    logic [31:0] cur_hrdata;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    assign hready0 = hro0 & hready_ovr;
    assign hready1 = hro1 & hready_ovr;
    assign hready2 = hro2 & hready_ovr;

    always #5 clk = ~clk;

    ahb_lite_sram_slave #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .n_Rst(n_rst), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(hready0), .HREADYOUT(hro0), .HRESP(hresp0), .HRDATA(hrdata0));

    ahb_lite_sram_slave #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .n_Rst(n_rst), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(hready1), .HREADYOUT(hro1), .HRESP(hresp1), .HRDATA(hrdata1));

    ahb_lite_sram_slave #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .n_Rst(n_rst), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(hready2), .HREADYOUT(hro2), .HRESP(hresp2), .HRDATA(hrdata2));

    always_comb begin
        cur_hro    = hro0;
        cur_hresp  = hresp0;
        cur_hrdata = hrdata0;
        case (inst)
            2'd1: begin cur_hro = hro1; cur_hresp = hresp1; cur_hrdata = hrdata1; end
            2'd2: begin cur_hro = hro2; cur_hresp = hresp2; cur_hrdata = hrdata2; end
            default: ;
        endcase
    end

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : 3;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic rdy, input logic [1:0] resp);
        chk({tag, "_hreadyout"}, {31'd0, cur_hro}, {31'd0, rdy});
        chk({tag, "_hresp"}, {30'd0, cur_hresp}, {30'd0, resp});
    endtask

    task automatic check_read(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_rdata observed=%h expected=<empty queue>", tag, cur_hrdata);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_rdata"}, cur_hrdata, e);
        end
    endtask

    task automatic addr_ph(input int i, input logic [31:0] a, input logic w, input logic [2:0] s);
        inst   = 2'(i);
        hsel   = 3'b001 << i;
        htrans = 2'b10;
        haddr  = a;
        hwrite = w;
        hsize  = s;
    endtask

    task automatic bus_idle();
        hsel   = 3'b000;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    // One isolated transfer; for reads d is the expected word.
    task automatic xfer(input int i, input logic [31:0] a, input logic w,
                        input logic [2:0] s, input logic [31:0] d, input string tag);
        addr_ph(i, a, w, s);
        if (!w) exp_q.push_back(d);
        step();
        bus_idle();
        hwdata = w ? d : 32'($urandom);
        for (int k = 0; k < ws_of(i); k++) begin
            chk_out({tag, "_wait"}, 1'b0, 2'b00);
            chk({tag, "_wait_rdata"}, cur_hrdata, 32'h0);
            step();
        end
        chk_out({tag, "_done"}, 1'b1, 2'b00);
        if (!w) check_read(tag);
        else    chk({tag, "_wr_rdata"}, cur_hrdata, 32'h0);
        step();
    endtask

    task automatic err_xfer(input int i, input logic [31:0] a, input logic [2:0] s, input string tag);
        addr_ph(i, a, 1'b1, s);
        step();
        bus_idle();
        hwdata = 32'hBAD0_BAD0;
        chk_out({tag, "_err1"}, 1'b0, 2'b01);
        chk({tag, "_err1_rdata"}, cur_hrdata, 32'h0);
        step();
        chk_out({tag, "_err2"}, 1'b1, 2'b01);
        step();
        chk_out({tag, "_after"}, 1'b1, 2'b00);
    endtask

    initial begin
        n_rst      = 1'b0;
        hsel       = 3'b000;
        haddr      = 32'h0;
        htrans     = 2'b00;
        hwrite     = 1'b0;
        hsize      = 3'b010;
        hburst     = 3'b000;
        hprot      = 4'b0011;
        hwdata     = 32'h0;
        hready_ovr = 1'b1;
        inst       = 2'd0;

        step();
        for (int i = 0; i < 3; i++) begin
            inst = 2'(i);
            #1;
            chk_out("reset", 1'b1, 2'b00);
            chk("reset_rdata", cur_hrdata, 32'h0);
        end
        n_rst = 1'b1;
        step();

        // Zero-wait word write then read-back.
        xfer(0, BASE, 1'b1, 3'b010, 32'hDEAD_BEEF, "w_word");
        xfer(0, BASE, 1'b0, 3'b010, 32'hDEAD_BEEF, "r_word");

        // Byte and halfword lanes.
        xfer(0, BASE,     1'b1, 3'b010, 32'h0, "w_zero_a");
        xfer(0, BASE + 3, 1'b1, 3'b000, {8'hA5, 24'($urandom)}, "w_byte3");
        xfer(0, BASE,     1'b0, 3'b010, 32'hA500_0000, "r_byte3");
        xfer(0, BASE,     1'b1, 3'b010, 32'h0, "w_zero_b");
        xfer(0, BASE + 2, 1'b1, 3'b001, {16'h1234, 16'($urandom)}, "w_half2");
        xfer(0, BASE,     1'b0, 3'b010, 32'h1234_0000, "r_half2");
        xfer(0, BASE + 1, 1'b1, 3'b000, 32'hFFFF_5AFF, "w_byte1");
        xfer(0, BASE,     1'b0, 3'b010, 32'h1234_5A00, "r_byte1");

        // Two wait states.
        xfer(1, BASE + 16, 1'b1, 3'b010, 32'h5555_AAAA, "ws2_w16");
        xfer(1, BASE + 20, 1'b1, 3'b010, 32'h600D_CAFE, "ws2_w20");
        xfer(1, BASE + 16, 1'b0, 3'b010, 32'h5555_AAAA, "ws2_r16");

        // Next NONSEQ held during the waits is taken only at the completing edge.
        addr_ph(1, BASE + 16, 1'b0, 3'b010);
        exp_q.push_back(32'h5555_AAAA);
        step();
        addr_ph(1, BASE + 20, 1'b0, 3'b010);
        exp_q.push_back(32'h600D_CAFE);
        chk_out("ws2_hold_w1", 1'b0, 2'b00);
        step();
        chk_out("ws2_hold_w2", 1'b0, 2'b00);
        step();
        chk_out("ws2_hold_done", 1'b1, 2'b00);
        check_read("ws2_hold_first");
        step();
        bus_idle();
        chk_out("ws2_next_w1", 1'b0, 2'b00);
        step();
        chk_out("ws2_next_w2", 1'b0, 2'b00);
        step();
        chk_out("ws2_next_done", 1'b1, 2'b00);
        check_read("ws2_next");
        step();

        // ERROR responses leave memory untouched.
        xfer(0, BASE, 1'b1, 3'b010, 32'h1111_1111, "w_known");
        err_xfer(0, BASE + 2, 3'b010, "e_misal_word");
        xfer(0, BASE, 1'b0, 3'b010, 32'h1111_1111, "r_misal_word");
        err_xfer(0, BASE + 1, 3'b001, "e_misal_half");
        xfer(0, BASE, 1'b0, 3'b010, 32'h1111_1111, "r_misal_half");
        err_xfer(0, BASE, 3'b011, "e_size");
        xfer(0, BASE, 1'b0, 3'b010, 32'h1111_1111, "r_size");
        err_xfer(0, BASE + 32'h1000, 3'b010, "e_range");
        xfer(0, BASE, 1'b0, 3'b010, 32'h1111_1111, "r_range");

        // Legal read accepted in the ERR2 cycle.
        addr_ph(0, BASE + 1, 1'b1, 3'b010);
        step();
        bus_idle();
        chk_out("e_chain_err1", 1'b0, 2'b01);
        step();
        addr_ph(0, BASE, 1'b0, 3'b010);
        exp_q.push_back(32'h1111_1111);
        chk_out("e_chain_err2", 1'b1, 2'b01);
        step();
        bus_idle();
        chk_out("e_chain_done", 1'b1, 2'b00);
        check_read("e_chain");
        step();

        // Pipelined write A, read A, write B, read B.
        addr_ph(0, BASE + 8, 1'b1, 3'b010);
        step();
        hwdata = 32'hA1A2_A3A4;
        addr_ph(0, BASE + 8, 1'b0, 3'b010);
        exp_q.push_back(32'hA1A2_A3A4);
        chk_out("pipe_wa", 1'b1, 2'b00);
        chk("pipe_wa_rdata", cur_hrdata, 32'h0);
        step();
        hwdata = 32'($urandom);
        addr_ph(0, BASE + 12, 1'b1, 3'b010);
        chk_out("pipe_ra", 1'b1, 2'b00);
        check_read("pipe_ra");
        step();
        hwdata = 32'hB1B2_B3B4;
        addr_ph(0, BASE + 12, 1'b0, 3'b010);
        exp_q.push_back(32'hB1B2_B3B4);
        chk_out("pipe_wb", 1'b1, 2'b00);
        step();
        bus_idle();
        chk_out("pipe_rb", 1'b1, 2'b00);
        check_read("pipe_rb");
        step();

        // IDLE and BUSY with HSEL high are answered OKAY without a data phase.
        addr_ph(0, BASE + 24, 1'b1, 3'b010);
        step();
        hwdata = 32'hC0DE_0001;
        htrans = 2'b00;
        chk_out("idle_w", 1'b1, 2'b00);
        step();
        htrans = 2'b01;
        chk_out("idle_gap", 1'b1, 2'b00);
        chk("idle_gap_rdata", cur_hrdata, 32'h0);
        step();
        chk_out("busy_gap", 1'b1, 2'b00);
        chk("busy_gap_rdata", cur_hrdata, 32'h0);
        xfer(0, BASE + 24, 1'b0, 3'b010, 32'hC0DE_0001, "idle_r");

        // Address ignored while another slave holds HREADY low.
        hready_ovr = 1'b0;
        addr_ph(0, BASE, 1'b1, 3'b010);
        step();
        bus_idle();
        hready_ovr = 1'b1;
        hwdata = 32'hFFFF_FFFF;
        chk_out("hready_low", 1'b1, 2'b00);
        chk("hready_low_rdata", cur_hrdata, 32'h0);
        step();
        xfer(0, BASE, 1'b0, 3'b010, 32'h1111_1111, "hready_low_r");

        // Reset during the second wait cycle of a write.
        xfer(2, BASE + 40, 1'b1, 3'b010, 32'hCAFE_F00D, "ws3_w_old");
        addr_ph(2, BASE + 40, 1'b1, 3'b010);
        step();
        bus_idle();
        hwdata = 32'h1234_5678;
        chk_out("rst_w1", 1'b0, 2'b00);
        step();
        chk_out("rst_w2", 1'b0, 2'b00);
        n_rst = 1'b0;
        #1;
        chk_out("rst_mid", 1'b1, 2'b00);
        chk("rst_mid_rdata", cur_hrdata, 32'h0);
        step();
        n_rst = 1'b1;
        step();
        xfer(2, BASE + 40, 1'b0, 3'b010, 32'hCAFE_F00D, "ws3_r_old");

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
